uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter among NUM_REQ byte-stream requesters. A requester keeps its grant until its packet ends (the byte flagged last), so bytes from different packets never interleave on the serial line. The block drives the transmitter's data_available/data/req/busy handshake and holds each byte stable until the transmitter has latched it. A lock timeout stops a stalled requester from blocking the line forever.

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A grant is held until the last byte of a packet has been handed to the transmitter.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_data_available,
    output logic [7:0]                 tx_data,
    input  logic                       tx_req,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked,
    output logic                       lock_err
);

    localparam int          IDW       = $clog2(NUM_REQ);
    localparam logic [15:0] TMO_LIMIT = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] TMO_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOAD  = 2'd1,
        OFFER = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [15:0]      tmo_cnt_r;
    logic             buf_last_r;
    logic             scan_hit_s;
    logic [IDW-1:0]   scan_idx_s;
    logic             xfer_s;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return IDW'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDW-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin scan: walking downward lets the offset closest to rr_ptr win.
    always_comb begin
        scan_hit_s = |req_valid;
        scan_idx_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx_s = req_valid[wrap_add(rr_ptr_r, k)] ? wrap_add(rr_ptr_r, k) : scan_idx_s;
        end
    end

    assign xfer_s = req_valid[grant_id] & req_ready[grant_id];

    // Arbitration / transmitter handshake FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= ARB;
            rr_ptr_r          <= '0;
            grant_id          <= '0;
            locked            <= 1'b0;
            req_ready         <= '0;
            tx_data_available <= 1'b0;
            tx_data           <= 8'h00;
            lock_err          <= 1'b0;
            tmo_cnt_r         <= 16'h0000;
            buf_last_r        <= 1'b0;
        end else begin
            lock_err <= 1'b0;
            case (state_r)
                ARB: begin
                    if (scan_hit_s) begin
                        grant_id  <= scan_idx_s;
                        locked    <= 1'b1;
                        req_ready <= one_hot(scan_idx_s);
                        tmo_cnt_r <= 16'h0000;
                        state_r   <= LOAD;
                    end
                end
                LOAD: begin
                    if (xfer_s) begin
                        tx_data           <= req_data[8*grant_id +: 8];
                        buf_last_r        <= req_last[grant_id];
                        req_ready         <= '0;
                        tmo_cnt_r         <= 16'h0000;
                        tx_data_available <= 1'b1;
                        state_r           <= OFFER;
                    end else if (tmo_cnt_r == TMO_LIMIT) begin
                        lock_err  <= 1'b1;
                        locked    <= 1'b0;
                        req_ready <= '0;
                        rr_ptr_r  <= wrap_add(grant_id, 1);
                        state_r   <= ARB;
                    end else if (tmo_cnt_r != TMO_MAX) begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end
                OFFER: begin
                    if (tx_req) begin
                        tx_data_available <= 1'b0;
                        state_r           <= HOLD;
                    end
                end
                HOLD: begin
                    // The transmitter may still sample tx_data until it reports busy.
                    if (tx_busy) begin
                        if (buf_last_r) begin
                            locked   <= 1'b0;
                            rr_ptr_r <= wrap_add(grant_id, 1);
                            state_r  <= ARB;
                        end else begin
                            req_ready <= one_hot(grant_id);
                            tmo_cnt_r <= 16'h0000;
                            state_r   <= LOAD;
                        end
                    end
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester and transmitter models feed
// a byte scoreboard; grant order is logged and compared per scenario.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          tx_data_available;
    logic [7:0]    tx_data;
    logic          tx_req;
    logic          tx_busy;
    logic [1:0]    grant_id;
    logic          locked;
    logic          lock_err;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_data_available(tx_data_available), .tx_data(tx_data),
        .tx_req(tx_req), .tx_busy(tx_busy),
        .grant_id(grant_id), .locked(locked), .lock_err(lock_err)
    );

    typedef struct packed {
        logic [1:0] id;
        logic       last;
        logic [7:0] data;
    } src_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    src_t src_q[$];
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int grant_code = 0;
    int grant_cnt = 0;
    int busy_dly = 1;
    bit tx_en = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester model: presents the head of each requester's byte queue.
    initial begin : req_model
        logic [N-1:0] taken;
        logic [N-1:0] prev_ready;
        bit found;
        int idx;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        prev_ready = '0;
        forever begin
            @(posedge clk);
            taken = rst ? '0 : (req_valid & req_ready);
            #1;
            n_vec++;
            if ($countones(req_ready) > 1) begin
                n_err++;
                $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
            end
            if (req_ready != '0 && prev_ready == '0) begin
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        grant_code = grant_code * 10 + i + 1;
                        grant_cnt++;
                    end
                end
            end
            prev_ready = req_ready;
            for (int i = 0; i < N; i++) begin
                if (taken[i]) begin
                    idx = -1;
                    for (int j = 0; j < src_q.size(); j++) begin
                        if (idx < 0 && src_q[j].id == 2'(i)) idx = j;
                    end
                    if (idx >= 0) src_q.delete(idx);
                end
            end
            for (int i = 0; i < N; i++) begin
                found = 1'b0;
                req_valid[i] = 1'b0;
                req_last[i] = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                for (int j = 0; j < src_q.size(); j++) begin
                    if (!found && src_q[j].id == 2'(i)) begin
                        found = 1'b1;
                        req_valid[i] = 1'b1;
                        req_last[i] = src_q[j].last;
                        req_data[8*i +: 8] = src_q[j].data;
                    end
                end
            end
        end
    end

    // Transmitter model: takes offered bytes, checks them against the scoreboard
    // and checks the byte is held until busy rises busy_dly cycles later.
    initial begin : tx_model
        logic [7:0] sent;
        exp_t e;
        tx_req = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en && !rst && tx_data_available && !tx_busy) begin
                sent = tx_data;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_unexpected: got byte %h from %0d, required no byte", sent, grant_id);
                end else begin
                    e = exp_q.pop_front();
                    if (sent !== e.data || grant_id !== e.id) begin
                        n_err++;
                        $display("FAIL tx_byte: got %h from %0d, required %h from %0d", sent, grant_id, e.data, e.id);
                    end
                end
                tx_req = 1'b1;
                @(negedge clk);
                tx_req = 1'b0;
                for (int k = 1; k < busy_dly; k++) begin
                    n_vec++;
                    if (tx_data !== sent || tx_data_available !== 1'b0 || req_ready !== '0) begin
                        n_err++;
                        $display("FAIL tx_hold: data=%h avail=%b ready=%b, required %h 0 0000", tx_data, tx_data_available, req_ready, sent);
                    end
                    @(negedge clk);
                end
                n_vec++;
                if (tx_data !== sent || tx_data_available !== 1'b0) begin
                    n_err++;
                    $display("FAIL tx_busy_edge: data=%h avail=%b, required %h 0", tx_data, tx_data_available, sent);
                end
                tx_busy = 1'b1;
                repeat (4) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic push_byte(input int id, input logic [7:0] data, input logic last);
        src_q.push_back('{id: 2'(id), last: last, data: data});
        exp_q.push_back('{id: 2'(id), data: data});
    endtask

    task automatic wait_idle(output bit ok);
        int k;
        ok = 1'b0;
        k = 0;
        while (!ok && k < 800) begin
            @(negedge clk);
            k++;
            ok = (exp_q.size() == 0 && src_q.size() == 0 && !locked && !tx_busy && !tx_req);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        grant_code = 0;
        grant_cnt = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (req_ready !== 4'b0000 || tx_data_available !== 1'b0 || tx_data !== 8'h00 ||
            grant_id !== 2'd0 || locked !== 1'b0 || lock_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: ready=%b avail=%b data=%h gid=%0d locked=%b err=%b, required all zero",
                     req_ready, tx_data_available, tx_data, grant_id, locked, lock_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_single;
        bit ok;
        @(negedge clk);
        grant_code = 0;
        grant_cnt = 0;
        push_byte(1, 8'h55, 1'b0);
        push_byte(1, 8'hA3, 1'b1);
        @(posedge clk); #2;
        n_vec++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL single_lat0: req_ready=%b, required 0000", req_ready);
        end
        @(posedge clk); #2;
        n_vec++;
        if (req_ready !== 4'b0010 || locked !== 1'b1 || grant_id !== 2'd1) begin
            n_err++;
            $display("FAIL single_grant: ready=%b locked=%b gid=%0d, required 0010 1 1", req_ready, locked, grant_id);
        end
        @(posedge clk); #2;
        n_vec++;
        if (tx_data_available !== 1'b1 || tx_data !== 8'h55 || req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL single_offer: avail=%b data=%h ready=%b, required 1 55 0000", tx_data_available, tx_data, req_ready);
        end
        wait_idle(ok);
        n_vec++;
        if (!ok || grant_code !== 22 || grant_id !== 2'd1 || tx_data !== 8'hA3) begin
            n_err++;
            $display("FAIL single_done: idle=%b order=%0d gid=%0d data=%h, required 1 22 1 a3", ok, grant_code, grant_id, tx_data);
        end
    endtask

    task automatic test_two_requesters;
        bit ok;
        do_reset();
        @(negedge clk);
        push_byte(0, 8'h10, 1'b0);
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h12, 1'b1);
        src_q.push_back('{id: 2'd2, last: 1'b0, data: 8'h20});
        src_q.push_back('{id: 2'd2, last: 1'b1, data: 8'h21});
        exp_q.push_back('{id: 2'd2, data: 8'h20});
        exp_q.push_back('{id: 2'd2, data: 8'h21});
        wait_idle(ok);
        n_vec++;
        if (!ok || grant_code !== 11133) begin
            n_err++;
            $display("FAIL two_order: idle=%b order=%0d, required 1 11133", ok, grant_code);
        end
        grant_code = 0;
        push_byte(3, 8'h3C, 1'b1);
        push_byte(0, 8'h0C, 1'b1);
        src_q.delete();
        src_q.push_back('{id: 2'd0, last: 1'b1, data: 8'h0C});
        src_q.push_back('{id: 2'd3, last: 1'b1, data: 8'h3C});
        wait_idle(ok);
        n_vec++;
        if (!ok || grant_code !== 41) begin
            n_err++;
            $display("FAIL two_rr_ptr: idle=%b order=%0d, required 1 41", ok, grant_code);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        do_reset();
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                push_byte(i, 8'(8'h40 + r * 16 + i), 1'b1);
            end
        end
        wait_idle(ok);
        n_vec++;
        if (!ok || grant_code !== 12341234 || grant_cnt !== 8) begin
            n_err++;
            $display("FAIL rr_order: idle=%b order=%0d count=%0d, required 1 12341234 8", ok, grant_code, grant_cnt);
        end
    endtask

    task automatic test_busy_delay;
        bit ok;
        @(negedge clk);
        busy_dly = 5;
        grant_code = 0;
        push_byte(2, 8'h5A, 1'b0);
        push_byte(2, 8'hC3, 1'b1);
        wait_idle(ok);
        n_vec++;
        if (!ok || grant_code !== 33 || tx_data !== 8'hC3) begin
            n_err++;
            $display("FAIL busy_delay: idle=%b order=%0d data=%h, required 1 33 c3", ok, grant_code, tx_data);
        end
        busy_dly = 1;
    endtask

    task automatic test_timeout;
        bit ok;
        int k;
        do_reset();
        @(negedge clk);
        push_byte(3, 8'h33, 1'b0);
        k = 0;
        while (grant_cnt < 1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        push_byte(0, 8'h0A, 1'b1);
        k = 0;
        while (!(exp_q.size() == 1 && req_ready === 4'b1000) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 100) begin
            n_err++;
            $display("FAIL tmo_reload: req_ready=%b, required 1000 within 100 cycles", req_ready);
        end
        k = 0;
        while (lock_err !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k !== 16 || locked !== 1'b0 || req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL tmo_pulse: cycles=%0d locked=%b ready=%b, required 16 0 0000", k, locked, req_ready);
        end
        @(negedge clk);
        n_vec++;
        if (lock_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_width: lock_err=%b one cycle later, required 0", lock_err);
        end
        wait_idle(ok);
        n_vec++;
        if (!ok || grant_code !== 441) begin
            n_err++;
            $display("FAIL tmo_next: idle=%b order=%0d, required 1 441", ok, grant_code);
        end
    endtask

    task automatic test_reset_offer;
        bit ok;
        bit seen;
        int k;
        @(negedge clk);
        tx_en = 1'b0;
        push_byte(1, 8'h7E, 1'b1);
        k = 0;
        while (tx_data_available !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (tx_data_available !== 1'b1 || tx_data !== 8'h7E) begin
            n_err++;
            $display("FAIL rst_offer_pre: avail=%b data=%h, required 1 7e", tx_data_available, tx_data);
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        n_vec++;
        if (req_ready !== 4'b0000 || tx_data_available !== 1'b0 || tx_data !== 8'h00 ||
            grant_id !== 2'd0 || locked !== 1'b0 || lock_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_offer_vals: ready=%b avail=%b data=%h gid=%0d locked=%b err=%b, required all zero",
                     req_ready, tx_data_available, tx_data, grant_id, locked, lock_err);
        end
        rst = 1'b0;
        tx_en = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx_data_available !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL rst_offer_drop: tx_data_available rose after reset, required 0");
        end
        grant_code = 0;
        push_byte(0, 8'hC0, 1'b1);
        push_byte(3, 8'hC3, 1'b1);
        wait_idle(ok);
        n_vec++;
        if (!ok || grant_code !== 14) begin
            n_err++;
            $display("FAIL rst_offer_ptr: idle=%b order=%0d, required 1 14", ok, grant_code);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        rst = 1'b1;
        test_reset();
        test_single();
        test_two_requesters();
        test_round_robin();
        test_busy_delay();
        test_timeout();
        test_reset_offer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
